// File: rtl/rsa_run_controller.sv
// -----------------------------------------------------------------------------
// rsa_run_controller
//
// Sequences one complete run of the RSA pipeline CPU:
//   1. On a rising edge of start, hold the core in reset for RST_CYCLES cycles.
//   2. Release the core and raise cpu_start. Then wait for cpu_end_flag, giving
//      up after TIMEOUT_CYCLES cycles.
//   3. Read RESULT_LEN bytes from data memory starting at RESULT_BASE. Stream
//      each byte to the host over a valid/ready byte interface.
//
// Optional feature (macro RSA_CTRL_CHECKSUM_EN):
//   After the last result byte, one extra byte is presented. It is the XOR of
//   all accepted result bytes.
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous active-low reset
//   start         run request (rising-edge detected)
//   cpu_end_flag  EndFlag from the core, honoured only while the core runs
//   cpu_reset     active-high reset to the core
//   cpu_start     start line to the core
//   mem_rd_en     one-cycle data-memory read strobe
//   mem_addr      data-memory byte address (wraps modulo 2^ADDR_W)
//   mem_rdata     read data, valid READ_LAT cycles after mem_rd_en
//   out_valid     out_byte valid
//   out_ready     consumer accepts out_byte
//   out_byte      streamed result byte
//   busy          run in progress (not IDLE/DONE/ERR)
//   done          run finished and every byte streamed
//   timeout_err   core never raised its end flag
//   byte_count    bytes accepted in the current run
// -----------------------------------------------------------------------------
module rsa_run_controller #(
  parameter int unsigned       ADDR_W         = 16,
  parameter logic [ADDR_W-1:0] RESULT_BASE    = 16'h0400,
  parameter int unsigned       RESULT_LEN     = 64,
  parameter int unsigned       RST_CYCLES     = 2,
  parameter int unsigned       READ_LAT       = 1,
  parameter int unsigned       TIMEOUT_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              cpu_end_flag,
  output logic              cpu_reset,
  output logic              cpu_start,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_byte,
  output logic              busy,
  output logic              done,
  output logic              timeout_err,
  output logic [ADDR_W:0]   byte_count
);

  // One shared counter covers the reset hold, the read latency and the
  // run timeout, so it is sized for the largest of the three.
  localparam int unsigned TO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned AUX_MAX = (RST_CYCLES > READ_LAT) ? RST_CYCLES : READ_LAT;
  localparam int unsigned AUX_W   = $clog2(AUX_MAX + 1);
  localparam int unsigned CNT_W   = (TO_W > AUX_W) ? TO_W : AUX_W;

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(READ_LAT - 1);
  localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [ADDR_W:0]  LEN_LAST = (ADDR_W+1)'(RESULT_LEN - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_CORE_RST,
    S_RUN,
    S_READ_REQ,
    S_READ_WAIT,
    S_PRESENT,
`ifdef RSA_CTRL_CHECKSUM_EN
    S_CHECKSUM,
`endif
    S_DONE,
    S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic              start_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        out_byte_q, out_byte_d;
  logic [ADDR_W:0]   byte_count_q, byte_count_d;
`ifdef RSA_CTRL_CHECKSUM_EN
  logic [7:0]        xor_q, xor_d;
`endif

  logic start_edge;
  assign start_edge = start & ~start_q;

  // NOTE: control outputs are decoded from state rather than registered.
  // Because the state register resets asynchronously, out_valid, busy and
  // cpu_reset fall back to their reset values at once when reset asserts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      start_q      <= 1'b0;
      cnt_q        <= '0;
      mem_addr_q   <= '0;
      out_byte_q   <= '0;
      byte_count_q <= '0;
`ifdef RSA_CTRL_CHECKSUM_EN
      xor_q        <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments keep every register sampling the
      // pre-edge values, independent of statement order.
      state_q      <= state_d;
      start_q      <= start;
      cnt_q        <= cnt_d;
      mem_addr_q   <= mem_addr_d;
      out_byte_q   <= out_byte_d;
      byte_count_q <= byte_count_d;
`ifdef RSA_CTRL_CHECKSUM_EN
      xor_q        <= xor_d;
`endif
    end
  end

  always_comb begin
    // NOTE: every variable driven here gets a default first. This means
    // no path can leave one unassigned and infer a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    mem_addr_d   = mem_addr_q;
    out_byte_d   = out_byte_q;
    byte_count_d = byte_count_q;
`ifdef RSA_CTRL_CHECKSUM_EN
    xor_d        = xor_q;
`endif
    cpu_reset    = 1'b1;
    cpu_start    = 1'b0;
    mem_rd_en    = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    timeout_err  = 1'b0;

    unique case (state_q)
      S_IDLE: busy = 1'b0;

      S_CORE_RST: begin
        if (cnt_q == RST_LAST) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_RUN: begin
        cpu_reset = 1'b0;
        cpu_start = 1'b1;
        cnt_d     = cnt_q + CNT_W'(1);
        // The end flag takes priority over a timeout in the same cycle.
        if (cpu_end_flag) begin
          state_d    = S_READ_REQ;
          mem_addr_d = RESULT_BASE;
        end else if (cnt_d == TO_LIMIT) begin
          state_d = S_ERR;
        end
      end

      S_READ_REQ: begin
        cpu_reset = 1'b0;
        mem_rd_en = 1'b1;
        cnt_d     = '0;
        state_d   = S_READ_WAIT;
      end

      S_READ_WAIT: begin
        cpu_reset = 1'b0;
        if (cnt_q == LAT_LAST) begin
          out_byte_d = mem_rdata;
          state_d    = S_PRESENT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_PRESENT: begin
        cpu_reset = 1'b0;
        out_valid = 1'b1;
        if (out_ready) begin
          byte_count_d = byte_count_q + (ADDR_W+1)'(1);
`ifdef RSA_CTRL_CHECKSUM_EN
          xor_d        = xor_q ^ out_byte_q;
`endif
          if (byte_count_q == LEN_LAST) begin
`ifdef RSA_CTRL_CHECKSUM_EN
            out_byte_d = xor_q ^ out_byte_q;
            state_d    = S_CHECKSUM;
`else
            state_d    = S_DONE;
`endif
          end else begin
            mem_addr_d = mem_addr_q + ADDR_W'(1);
            state_d    = S_READ_REQ;
          end
        end
      end

`ifdef RSA_CTRL_CHECKSUM_EN
      S_CHECKSUM: begin
        cpu_reset = 1'b0;
        out_valid = 1'b1;
        if (out_ready) begin
          byte_count_d = byte_count_q + (ADDR_W+1)'(1);
          state_d      = S_DONE;
        end
      end
`endif

      S_DONE: begin
        busy = 1'b0;
        done = 1'b1;
      end

      S_ERR: begin
        busy        = 1'b0;
        timeout_err = 1'b1;
      end

      default: state_d = S_IDLE;
    endcase

    // A new run may only be launched from an idle state. Start edges seen
    // while busy are dropped rather than queued.
    if (!busy && start_edge) begin
      state_d      = S_CORE_RST;
      cnt_d        = '0;
      byte_count_d = '0;
`ifdef RSA_CTRL_CHECKSUM_EN
      xor_d        = '0;
`endif
    end
  end

  assign mem_addr   = mem_addr_q;
  assign out_byte   = out_byte_q;
  assign byte_count = byte_count_q;

endmodule

// File: tb/tb_rsa_run_controller.sv
// -----------------------------------------------------------------------------
// tb_rsa_run_controller
//
// Bench for rsa_run_controller. It models the core (end flag after a chosen
// delay), a data memory with one cycle of read latency, and a host whose
// readiness is steady, toggles every 3 cycles, or is random.
//
// Expected bytes are derived from the memory image and pushed into a queue
// when each run is prepared. An independent monitor compares every presented
// byte against the queue head. Sequence checks (core reset hold, run length,
// final status) are done in the stimulus thread.
// -----------------------------------------------------------------------------
module tb_rsa_run_controller;

  localparam int          ADDR_W = 16;
  localparam logic [15:0] BASE   = 16'h0400;
  localparam int          LEN    = 64;
  localparam int          RSTC   = 2;
  localparam int          LAT    = 1;
  localparam int          TO     = 100;
  localparam int          NEVER  = 100000;
`ifdef RSA_CTRL_CHECKSUM_EN
  localparam int          EXTRA  = 1;
`else
  localparam int          EXTRA  = 0;
`endif

  logic              clk = 1'b1;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              cpu_end_flag = 1'b0;
  logic [7:0]        mem_rdata = 8'h00;
  logic              out_ready = 1'b0;
  logic              cpu_reset, cpu_start, mem_rd_en, out_valid, busy, done, timeout_err;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        out_byte;
  logic [ADDR_W:0]   byte_count;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0]  mem [0:65535];
  logic [7:0]  exp_q [$];
  int          acc_cnt    = 0;
  int          rd_cnt     = 0;
  int          run_cyc    = 0;
  int          ready_mode = 0;
  logic [15:0] exp_addr;

  rsa_run_controller #(
    .ADDR_W        (ADDR_W),
    .RESULT_BASE   (BASE),
    .RESULT_LEN    (LEN),
    .RST_CYCLES    (RSTC),
    .READ_LAT      (LAT),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .cpu_end_flag(cpu_end_flag),
    .cpu_reset   (cpu_reset),
    .cpu_start   (cpu_start),
    .mem_rd_en   (mem_rd_en),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_byte    (out_byte),
    .busy        (busy),
    .done        (done),
    .timeout_err (timeout_err),
    .byte_count  (byte_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Data memory: address sampled mid-cycle while the strobe is high. Data
  // appears one cycle later. Any other cycle carries random junk, so that
  // a mistimed capture is caught.
  initial begin
    logic        hit;
    logic [15:0] a;
    forever begin
      @(negedge clk);
      hit = mem_rd_en;
      a   = mem_addr;
      @(posedge clk);
      #1;
      mem_rdata = hit ? mem[a] : 8'($urandom);
    end
  end

  // Host readiness: 0 = always ready, 1 = 3 cycles on / 3 off, else random.
  initial begin
    int ph = 0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       begin out_ready = ((ph / 3) % 2) == 0; ph++; end
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: read addresses, presented bytes (stalled or accepted), RUN length.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        if (cpu_start) run_cyc++;
        if (mem_rd_en) begin
          exp_addr = BASE + 16'(rd_cnt);
          check("rd_addr", 32'(mem_addr), 32'(exp_addr));
          rd_cnt++;
        end
        if (out_valid) begin
          check("q_has_entry", 32'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            if (out_ready) begin
              check("byte", 32'(out_byte), 32'(exp_q.pop_front()));
              acc_cnt++;
            end else begin
              check("stall_byte", 32'(out_byte), 32'(exp_q[0]));
            end
          end
        end
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_cpu_reset"},   32'(cpu_reset), 1);
    check({tag, "_cpu_start"},   32'(cpu_start), 0);
    check({tag, "_mem_rd_en"},   32'(mem_rd_en), 0);
    check({tag, "_mem_addr"},    32'(mem_addr), 0);
    check({tag, "_out_valid"},   32'(out_valid), 0);
    check({tag, "_out_byte"},    32'(out_byte), 0);
    check({tag, "_busy"},        32'(busy), 0);
    check({tag, "_done"},        32'(done), 0);
    check({tag, "_timeout_err"}, 32'(timeout_err), 0);
    check({tag, "_byte_count"},  32'(byte_count), 0);
  endtask

  // kind: 0 = ramp 0x00.., 1 = random, 2 = all 0xA5.
  task automatic prep_run(input int kind, input int rmode, input int delay);
    logic [7:0]  x;
    logic [15:0] a;
    x = 8'h00;
    for (int i = 0; i < LEN; i++) begin
      a = BASE + 16'(i);
      case (kind)
        0:       mem[a] = 8'(i);
        1:       mem[a] = 8'($urandom);
        default: mem[a] = 8'hA5;
      endcase
      if (delay < TO) begin
        exp_q.push_back(mem[a]);
        x = x ^ mem[a];
      end
    end
    if (EXTRA != 0 && delay < TO) exp_q.push_back(x);
    acc_cnt    = 0;
    rd_cnt     = 0;
    run_cyc    = 0;
    ready_mode = rmode;
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1 start = 1'b1;
  endtask

  // Runs one sequence after the start edge has been issued. delay is the
  // number of RUN cycles before the end flag (>= TO means never). abort_at
  // > 0 pulls reset after that many accepted bytes.
  task automatic run_body(input int delay, input bit dbl, input int abort_at);
    int hold;
    bit seen;
    hold = 0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (cpu_start) seen = 1'b1;
      else if (busy && cpu_reset) hold++;
    end
    check("cpu_reset_hold", 32'(hold), RSTC);
    check("cpu_start_seen", 32'(seen), 1);
    if (!seen) return;

    for (int c = 0; c < delay && c < TO + 20; c++) begin
      @(posedge clk);
      #1;
      if (dbl && c == 3) start = 1'b0;
      if (dbl && c == 4) start = 1'b1;
    end
    if (delay < TO) cpu_end_flag = 1'b1;

    if (abort_at > 0) begin
      for (int i = 0; i < 3000 && acc_cnt < abort_at; i++) @(posedge clk);
      check("abort_point", 32'(acc_cnt), 32'(abort_at));
      #2;
      reset        = 1'b0;
      start        = 1'b0;
      cpu_end_flag = 1'b0;
      #1;
      check_reset_vals("abort");
      exp_q.delete();
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      return;
    end

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    cpu_end_flag = 1'b0;
    check("idle_after_run", 32'(busy), 0);
    check("cpu_reset_after", 32'(cpu_reset), 1);
    check("valid_after", 32'(out_valid), 0);
    if (delay < TO) begin
      check("run_cycles", 32'(run_cyc), 32'(delay + 1));
      check("done", 32'(done), 1);
      check("timeout_err", 32'(timeout_err), 0);
      check("byte_count", 32'(byte_count), 32'(LEN + EXTRA));
      check("accepted", 32'(acc_cnt), 32'(LEN + EXTRA));
      check("reads", 32'(rd_cnt), 32'(LEN));
      check("queue_empty", 32'(exp_q.size()), 0);
    end else begin
      check("timeout_cycles", 32'(run_cyc), 32'(TO));
      check("timeout_err_set", 32'(timeout_err), 1);
      check("timeout_done", 32'(done), 0);
      check("timeout_reads", 32'(rd_cnt), 0);
      check("timeout_bytes", 32'(acc_cnt), 0);
    end
    if (dbl) begin
      repeat (20) @(negedge clk);
      check("no_second_run", 32'(busy), 0);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;

    // Reset state, then the nominal run: start rises shortly after release.
    #12;
    check_reset_vals("por");
    prep_run(0, 0, 40);
    #10 reset = 1'b1;
    #3  start = 1'b1;
    run_body(40, 1'b0, 0);

    // Backpressure with a ramp pattern.
    prep_run(0, 1, 25);
    pulse_start();
    run_body(25, 1'b0, 0);

    // Timeout: the core never finishes.
    prep_run(1, 0, NEVER);
    pulse_start();
    run_body(NEVER, 1'b0, 0);

    // End flag on the very cycle the timeout would fire.
    prep_run(1, 2, TO - 1);
    pulse_start();
    run_body(TO - 1, 1'b0, 0);

    // A second start edge in RUN must be ignored.
    prep_run(1, 0, 40);
    pulse_start();
    run_body(40, 1'b1, 0);

    // Randomized runs.
    for (int r = 0; r < 4; r++) begin
      int d;
      d = int'($urandom_range(1, 90));
      prep_run(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), d);
      pulse_start();
      run_body(d, 1'b0, 0);
    end

    // Reset mid-stream after 10 accepted bytes, then a full clean run.
    prep_run(0, 2, 15);
    pulse_start();
    run_body(15, 1'b0, 10);
    prep_run(0, 0, 30);
    pulse_start();
    run_body(30, 1'b0, 0);

    // Constant pattern.
    prep_run(2, 1, 10);
    pulse_start();
    run_body(10, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
